// File: rtl/adder_tree_acc.sv
// adder_tree_acc
//   Streaming reduction stage: a binary adder tree sums DATA_N words per beat,
//   then an accumulator adds ACC_N consecutive tree results into one output.
//   Each tree layer is either combinational or registered, as selected by FF_P.
//   The valid flag follows the data through the tree with the same delay.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   i_valid  in   i_data carries a beat this cycle
//   i_data   in   DATA_N words of DATA_W bits, index 0 first
//   i_clear  in   synchronous flush of tree valids and any partial accumulation
//   o_valid  out  one-cycle pulse; o_data holds a new total
//   o_data   out  accumulated total, held until the next o_valid
//   o_busy   out  a valid is held in a tree register or a partial total is open
//
// Accumulator states
//   state  | meaning
//   S_IDLE | no partial total open; the next tree result starts a new total
//   S_ACC  | partial total open in acc_q; cnt_q results collected so far

module adder_tree_acc #(
    parameter int                     DATA_W = 5,
    parameter int                     DATA_N = 11,
    parameter logic [$clog2(DATA_N)-1:0] FF_P = '0,
    parameter bit                     SIGNED = 1'b0,
    parameter int                     ACC_N  = 1,
    localparam int                    TREE_W   = DATA_W + $clog2(DATA_N),
    localparam int                    ACC_W    = (ACC_N > 1) ? $clog2(ACC_N) : 0,
    localparam int                    O_DATA_W = TREE_W + ACC_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_valid,
    input  logic [0:DATA_N-1][DATA_W-1:0]  i_data,
    input  logic                           i_clear,
    output logic                           o_valid,
    output logic [O_DATA_W-1:0]            o_data,
    output logic                           o_busy
);

    localparam int STAGES_N = $clog2(DATA_N);
    localparam int VEC_W    = DATA_N * TREE_W;
    localparam int CNT_W    = (ACC_N > 1) ? $clog2(ACC_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_N - 1);

    // Number of nodes feeding layer l (l = 0 are the leaves).
    function automatic int nodes(input int l);
        return (DATA_N + (1 << l) - 1) >> l;
    endfunction

    // Every node is carried at the full tree width; extending the leaves once
    // up front gives the same result as widening by one bit per layer.
    logic [STAGES_N:0][VEC_W-1:0] lvl;
    logic [STAGES_N:0]            vld;
    logic [STAGES_N-1:0]          vld_reg;
    logic [VEC_W-1:0]             leaf_vec;

    always_comb begin
        leaf_vec = '0;
        for (int i = 0; i < DATA_N; i++) begin
            if (SIGNED)
                leaf_vec[i*TREE_W +: TREE_W] = {{(TREE_W-DATA_W){i_data[i][DATA_W-1]}}, i_data[i]};
            else
                leaf_vec[i*TREE_W +: TREE_W] = {{(TREE_W-DATA_W){1'b0}}, i_data[i]};
        end
    end

    // A beat presented together with i_clear is dropped.
    assign lvl[0] = leaf_vec;
    assign vld[0] = i_valid & ~i_clear;

    for (genvar k = 0; k < STAGES_N; k++) begin : g_lyr
        localparam int NI = nodes(k);
        localparam int NO = nodes(k + 1);
        logic [VEC_W-1:0] sum_d;

        // Pair nodes 2j and 2j+1; an odd leftover passes straight up.
        always_comb begin
            sum_d = '0;
            for (int j = 0; j < NO; j++) begin
                if (2*j + 1 < NI)
                    sum_d[j*TREE_W +: TREE_W] = lvl[k][2*j*TREE_W +: TREE_W]
                                              + lvl[k][(2*j+1)*TREE_W +: TREE_W];
                else
                    sum_d[j*TREE_W +: TREE_W] = lvl[k][2*j*TREE_W +: TREE_W];
            end
        end

        if (FF_P[k]) begin : g_ff
            logic [VEC_W-1:0] sum_q;
            logic             vld_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= i_clear ? 1'b0 : vld[k];
                    if (vld[k]) sum_q <= sum_d;
                end
            end
            assign lvl[k+1]   = sum_q;
            assign vld[k+1]   = vld_q;
            assign vld_reg[k] = vld_q;
        end else begin : g_comb
            assign lvl[k+1]   = sum_d;
            assign vld[k+1]   = vld[k];
            assign vld_reg[k] = 1'b0;
        end
    end

    // Node slots above each layer's live count are constant zero.
    logic unused_lvl;
    assign unused_lvl = ^lvl;

    logic                tree_v;
    logic [TREE_W-1:0]   tree;
    logic [O_DATA_W-1:0] tree_ext;

    assign tree_v = vld[STAGES_N] & ~i_clear;
    assign tree   = lvl[STAGES_N][TREE_W-1:0];

    if (ACC_W == 0) begin : g_ext_none
        assign tree_ext = tree;
    end else if (SIGNED) begin : g_ext_sign
        assign tree_ext = {{ACC_W{tree[TREE_W-1]}}, tree};
    end else begin : g_ext_zero
        assign tree_ext = {{ACC_W{1'b0}}, tree};
    end

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [O_DATA_W-1:0] acc_q, acc_d;
    logic [O_DATA_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (i_clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (tree_v) begin
            case (state_q)
                S_IDLE: begin
                    if (ACC_N == 1) begin
                        data_d  = tree_ext;
                        valid_d = 1'b1;
                    end else begin
                        acc_d   = tree_ext;
                        cnt_d   = CNT_W'(1);
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    if (cnt_q == CNT_LAST) begin
                        data_d  = acc_q + tree_ext;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        acc_d = acc_q + tree_ext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_busy  = (|vld_reg) | (state_q == S_ACC);

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc. Four instances:
//   u_dut0  FF_P=0101 unsigned ACC_N=1 (latency 3)
//   u_dut1  FF_P=0101 signed   ACC_N=1 (latency 3)
//   u_dut2  FF_P=0101 unsigned ACC_N=4
//   u_dut3  FF_P=0000 unsigned ACC_N=1 (latency 1)
// Only one instance is driven per cycle; expected totals and their due cycle
// go into a scoreboard queue and are popped when any o_valid appears.

module tb_adder_tree_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_i [4];
    logic        clr_i [4];
    logic [54:0] dat_i [4];
    logic        ov [4];
    logic        ob [4];
    logic [8:0]  od0, od1, od3;
    logic [10:0] od2;

    adder_tree_acc #(.DATA_W(5), .DATA_N(11), .FF_P(4'b0101), .SIGNED(1'b0), .ACC_N(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_valid(vld_i[0]), .i_data(dat_i[0]), .i_clear(clr_i[0]),
        .o_valid(ov[0]), .o_data(od0), .o_busy(ob[0]));
    adder_tree_acc #(.DATA_W(5), .DATA_N(11), .FF_P(4'b0101), .SIGNED(1'b1), .ACC_N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(vld_i[1]), .i_data(dat_i[1]), .i_clear(clr_i[1]),
        .o_valid(ov[1]), .o_data(od1), .o_busy(ob[1]));
    adder_tree_acc #(.DATA_W(5), .DATA_N(11), .FF_P(4'b0101), .SIGNED(1'b0), .ACC_N(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(vld_i[2]), .i_data(dat_i[2]), .i_clear(clr_i[2]),
        .o_valid(ov[2]), .o_data(od2), .o_busy(ob[2]));
    adder_tree_acc #(.DATA_W(5), .DATA_N(11), .FF_P(4'b0000), .SIGNED(1'b0), .ACC_N(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_valid(vld_i[3]), .i_data(dat_i[3]), .i_clear(clr_i[3]),
        .o_valid(ov[3]), .o_data(od3), .o_busy(ob[3]));

    typedef struct {
        int     u;
        longint val;
        int     due;
    } sb_t;

    sb_t sbq[$];
    sb_t mon_e;
    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint out_of(input int u);
        case (u)
            0:       return longint'(od0);
            1:       return longint'(od1);
            2:       return longint'(od2);
            default: return longint'(od3);
        endcase
    endfunction

    function automatic logic [54:0] fill(input int w);
        logic [4:0] w5;
        w5 = w[4:0];
        return {11{w5}};
    endfunction

    // Reference sum of the 11 words, truncated to the output width.
    function automatic longint model_sum(input logic [54:0] d, input bit sgn, input int ow);
        longint s;
        logic [4:0] w;
        s = 0;
        for (int i = 0; i < 11; i++) begin
            w = d[i*5 +: 5];
            if (sgn && w[4]) s += longint'(w) - 32;
            else             s += longint'(w);
        end
        return s & ((longint'(1) << ow) - 1);
    endfunction

    task automatic drive(input int u, input bit v, input bit c, input logic [54:0] d);
        for (int k = 0; k < 4; k++) begin
            vld_i[k] = 1'b0;
            clr_i[k] = 1'b0;
            dat_i[k] = '0;
        end
        vld_i[u] = v;
        clr_i[u] = c;
        dat_i[u] = d;
    endtask

    task automatic push(input int u, input longint val, input int lat);
        sb_t e;
        e.u   = u;
        e.val = val;
        e.due = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic beat(input int u, input logic [54:0] d, input bit sgn, input int lat);
        @(negedge clk);
        drive(u, 1'b1, 1'b0, d);
        push(u, model_sum(d, sgn, 9), lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, '0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 4; u++) begin
                if (ov[u]) begin
                    if (sbq.size() == 0) begin
                        chk($sformatf("u%0d_unexpected_out", u), sbq.size(), 1);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk($sformatf("u%0d_out_unit", u), u, mon_e.u);
                        chk($sformatf("u%0d_out_data", u), out_of(u), mon_e.val);
                        chk($sformatf("u%0d_out_cycle", u), cyc, mon_e.due);
                    end
                end
            end
        end
    end

    initial begin
        int          pat [6];
        logic [54:0] d;
        pat = '{1, 1, 0, 0, 1, 1};
        drive(0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #12;
        chk("rst_valid", ov[0], 0);
        chk("rst_data", od0, 0);
        chk("rst_busy", ob[0], 0);
        chk("rst_acc_data", od2, 0);
        chk("rst_acc_busy", ob[2], 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single beats, unsigned and signed.
        beat(0, fill(31), 1'b0, 3);
        idle(5);
        beat(1, fill(16), 1'b1, 3);
        idle(4);
        beat(1, fill(15), 1'b1, 3);
        idle(4);

        // Non-uniform words exercise the pairing and odd-leftover paths.
        for (int r = 0; r < 4; r++) begin
            d = 55'({$urandom(), $urandom()});
            beat(0, d, 1'b0, 3);
            beat(1, d, 1'b1, 3);
        end
        idle(5);

        // ACC_N=4 with a gap between beats 2 and 3; busy until the total lands.
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            if (s > 0) chk("acc_busy", ob[2], 1);
            drive(2, pat[s] != 0, 1'b0, fill(31));
            if (s == 5) push(2, 1364, 3);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("acc_busy_tail", ob[2], (k < 3) ? 1 : 0);
            drive(0, 1'b0, 1'b0, '0);
        end
        idle(2);

        // Two beats, then clear (with a valid that must be dropped), then 4 beats of 1.
        @(negedge clk); drive(2, 1'b1, 1'b0, fill(31));
        @(negedge clk); drive(2, 1'b1, 1'b0, fill(31));
        @(negedge clk); drive(2, 1'b1, 1'b1, fill(31));
        @(negedge clk);
        chk("clr_busy", ob[2], 0);
        chk("clr_data_kept", od2, 1364);
        drive(2, 1'b1, 1'b0, fill(1));
        @(negedge clk); drive(2, 1'b1, 1'b0, fill(1));
        @(negedge clk); drive(2, 1'b1, 1'b0, fill(1));
        @(negedge clk); drive(2, 1'b1, 1'b0, fill(1));
        push(2, 44, 3);
        idle(5);

        // Back-to-back beats, registered and fully combinational trees.
        for (int n = 1; n <= 8; n++) beat(0, fill(n), 1'b0, 3);
        idle(5);
        for (int n = 1; n <= 8; n++) beat(3, fill(n), 1'b0, 1);
        idle(3);

        // Async reset with two beats in flight: nothing may come out.
        @(negedge clk); drive(0, 1'b1, 1'b0, fill(3));
        @(negedge clk); drive(0, 1'b1, 1'b0, fill(4));
        @(negedge clk); drive(0, 1'b0, 1'b0, '0);
        chk("pre_rst_busy", ob[0], 1);
        chk("pre_rst_data", od0, 88);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov[0], 0);
        chk("mid_rst_data", od0, 0);
        chk("mid_rst_busy", ob[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        chk("post_rst_busy", ob[0], 0);

        for (int t = 0; t < 20 && sbq.size() > 0; t++) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
